// File: rtl/wb_stage.sv
// wb_stage: MEM/WB pipeline register and writeback stage of the PD5 pipeline.
// Captures the completing instruction from MEM, forms the writeback value
// (ALU result, extended load data, PC+4 or zero), drives the register file
// write port and bypasses the WB result to the ID-stage operand reads.
// Optional feature macro: WB_RETIRE_COUNTER_EN (adds retire_pulse/retire_count).
module wb_stage #(
    parameter int               XLEN     = 32,
    parameter logic [XLEN-1:0]  RESET_PC = 32'h0100_0000
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    input  logic            flush,
    input  logic            in_valid,
    input  logic            in_reg_we,
    input  logic [4:0]      in_rd,
    input  logic [1:0]      in_wb_sel,
    input  logic [2:0]      in_funct3,
    input  logic [XLEN-1:0] in_alu_result,
    input  logic [XLEN-1:0] in_pc,
    input  logic [XLEN-1:0] in_mem_rdata,
    input  logic [4:0]      id_rs1,
    input  logic [4:0]      id_rs2,
    input  logic [XLEN-1:0] id_rf_rs1,
    input  logic [XLEN-1:0] id_rf_rs2,
    output logic [4:0]      addr_rd,
    output logic [XLEN-1:0] data_rd,
    output logic            write_enable,
    output logic [XLEN-1:0] id_rs1_data,
    output logic [XLEN-1:0] id_rs2_data
`ifdef WB_RETIRE_COUNTER_EN
    ,
    output logic            retire_pulse,
    output logic [63:0]     retire_count
`endif
);

    localparam logic [1:0] WB_ALU  = 2'd0;
    localparam logic [1:0] WB_LOAD = 2'd1;
    localparam logic [1:0] WB_PC4  = 2'd2;

    logic            valid_q;
    logic            we_q;
    logic            done_q;
    logic [4:0]      rd_q;
    logic [XLEN-1:0] data_q;
    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] load_val;
    logic [XLEN-1:0] wb_val;
    logic            first_cycle;

    // Select and extend the addressed byte/halfword of the aligned load word.
    always_comb begin
        logic [7:0]  b;
        logic [15:0] h;
        b = 8'h00;
        case (in_alu_result[1:0])
            2'd0: b = in_mem_rdata[7:0];
            2'd1: b = in_mem_rdata[15:8];
            2'd2: b = in_mem_rdata[23:16];
            default: b = in_mem_rdata[31:24];
        endcase
        // off[0] is ignored for halfwords: misalignment is not trapped.
        h = in_alu_result[1] ? in_mem_rdata[31:16] : in_mem_rdata[15:0];
        case (in_funct3)
            3'b000:  load_val = {{(XLEN-8){b[7]}}, b};
            3'b100:  load_val = {{(XLEN-8){1'b0}}, b};
            3'b001:  load_val = {{(XLEN-16){h[15]}}, h};
            3'b101:  load_val = {{(XLEN-16){1'b0}}, h};
            default: load_val = in_mem_rdata;
        endcase
    end

    // Writeback value is formed at capture so WB outputs are pure registers.
    always_comb begin
        case (in_wb_sel)
            WB_ALU:  wb_val = in_alu_result;
            WB_LOAD: wb_val = load_val;
            WB_PC4:  wb_val = in_pc + XLEN'(4);
            default: wb_val = '0;
        endcase
    end

    // An instruction takes effect once: the first cycle it sits valid in WB.
    assign first_cycle  = valid_q & ~done_q;
    assign write_enable = first_cycle & we_q & (rd_q != 5'd0);
    assign addr_rd      = rd_q;
    assign data_rd      = data_q;

    // Bypass: the RF write only lands at the next edge, so forward it to ID now.
    assign id_rs1_data = (write_enable && rd_q == id_rs1) ? data_q : id_rf_rs1;
    assign id_rs2_data = (write_enable && rd_q == id_rs2) ? data_q : id_rf_rs2;

    // Pipeline register: flush beats stall; a held instruction is marked done
    // after its first cycle so the write (and retire) never repeats. pc_q is
    // a captured copy of the PC kept for debug visibility.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            we_q    <= 1'b0;
            done_q  <= 1'b0;
            rd_q    <= 5'd0;
            data_q  <= '0;
            pc_q    <= RESET_PC;
        end else if (flush) begin
            valid_q <= 1'b0;
            done_q  <= 1'b0;
        end else if (stall) begin
            if (first_cycle) done_q <= 1'b1;
        end else begin
            valid_q <= in_valid;
            we_q    <= in_reg_we;
            rd_q    <= in_rd;
            data_q  <= wb_val;
            pc_q    <= in_pc;
            done_q  <= 1'b0;
        end
    end

    // pc_q has no consumer inside this stage; fold it into a dead reduction
    // so it stays a named, probe-able register without an extra port.
    logic pc_unused;
    assign pc_unused = ^pc_q;

`ifdef WB_RETIRE_COUNTER_EN
    assign retire_pulse = first_cycle;

    // Count each valid instruction once, whether or not it writes rd.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)               retire_count <= 64'd0;
        else if (retire_pulse) retire_count <= retire_count + 64'd1;
    end
`endif

endmodule

// File: tb/tb_wb_stage.sv
// tb_wb_stage: directed, table-driven bench for wb_stage plus hand-written
// sequences for stall single-write, bypass, flush-vs-stall and async reset.
module tb_wb_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall, flush, in_valid, in_reg_we;
    logic [4:0]  in_rd;
    logic [1:0]  in_wb_sel;
    logic [2:0]  in_funct3;
    logic [31:0] in_alu_result, in_pc, in_mem_rdata;
    logic [4:0]  id_rs1, id_rs2;
    logic [31:0] id_rf_rs1, id_rf_rs2;
    logic [4:0]  addr_rd;
    logic [31:0] data_rd;
    logic        write_enable;
    logic [31:0] id_rs1_data, id_rs2_data;
`ifdef WB_RETIRE_COUNTER_EN
    logic        retire_pulse;
    logic [63:0] retire_count;
    logic [63:0] rc_before;
`endif

    int checks   = 0;
    int failures = 0;

    wb_stage dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .in_valid(in_valid), .in_reg_we(in_reg_we), .in_rd(in_rd),
        .in_wb_sel(in_wb_sel), .in_funct3(in_funct3),
        .in_alu_result(in_alu_result), .in_pc(in_pc), .in_mem_rdata(in_mem_rdata),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rf_rs1(id_rf_rs1), .id_rf_rs2(id_rf_rs2),
        .addr_rd(addr_rd), .data_rd(data_rd), .write_enable(write_enable),
        .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data)
`ifdef WB_RETIRE_COUNTER_EN
        , .retire_pulse(retire_pulse), .retire_count(retire_count)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [1:0]  wb_sel;
        logic [2:0]  f3;
        logic        we;
        logic [4:0]  rd;
        logic [31:0] alu;
        logic [31:0] pc;
        logic [31:0] mem;
        logic        exp_we;
        logic [4:0]  exp_rd;
        logic [31:0] exp_data;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    task automatic add(input string n, input logic [1:0] ws, input logic [2:0] f3,
                       input logic we, input logic [4:0] rd, input logic [31:0] alu,
                       input logic [31:0] pc, input logic [31:0] mem,
                       input logic ewe, input logic [4:0] erd, input logic [31:0] ed);
        vec_t v;
        v.name = n; v.wb_sel = ws; v.f3 = f3; v.we = we; v.rd = rd; v.alu = alu;
        v.pc = pc; v.mem = mem; v.exp_we = ewe; v.exp_rd = erd; v.exp_data = ed;
        vecs.push_back(v);
    endtask

    task automatic drive(input logic [1:0] ws, input logic [2:0] f3, input logic we,
                         input logic [4:0] rd, input logic [31:0] alu,
                         input logic [31:0] pc, input logic [31:0] mem);
        in_valid = 1'b1; in_wb_sel = ws; in_funct3 = f3; in_reg_we = we;
        in_rd = rd; in_alu_result = alu; in_pc = pc; in_mem_rdata = mem;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int wcnt;
        rst = 1'b1; stall = 1'b0; flush = 1'b0; in_valid = 1'b0; in_reg_we = 1'b0;
        in_rd = '0; in_wb_sel = '0; in_funct3 = '0; in_alu_result = '0; in_pc = '0;
        in_mem_rdata = '0; id_rs1 = '0; id_rs2 = '0; id_rf_rs1 = '0; id_rf_rs2 = '0;

        //   name        sel  f3    we rd  alu            pc             mem            ewe erd  edata
        add("lb_off3",   1, 3'b000, 1, 5,  32'h0000_0003, 32'h0,         32'h80FF_7F01, 1, 5,  32'hFFFF_FF80);
        add("lbu_off3",  1, 3'b100, 1, 5,  32'h0000_0003, 32'h0,         32'h80FF_7F01, 1, 5,  32'h0000_0080);
        add("lb_off1",   1, 3'b000, 1, 6,  32'h0000_0101, 32'h0,         32'h80FF_7F01, 1, 6,  32'h0000_007F);
        add("lhu_off2",  1, 3'b101, 1, 8,  32'h0000_0002, 32'h0,         32'hBEEF_1234, 1, 8,  32'h0000_BEEF);
        add("lh_off3",   1, 3'b001, 1, 8,  32'h0000_0003, 32'h0,         32'hBEEF_1234, 1, 8,  32'hFFFF_BEEF);
        add("lh_off0",   1, 3'b001, 1, 9,  32'h0000_0000, 32'h0,         32'h80FF_7F01, 1, 9,  32'h0000_7F01);
        add("lw_off1",   1, 3'b010, 1, 10, 32'h0000_0001, 32'h0,         32'hBEEF_1234, 1, 10, 32'hBEEF_1234);
        add("ld_f3_011", 1, 3'b011, 1, 11, 32'h0000_0002, 32'h0,         32'h1234_5678, 1, 11, 32'h1234_5678);
        add("alu",       0, 3'b000, 1, 12, 32'hCAFE_F00D, 32'h0,         32'hFFFF_FFFF, 1, 12, 32'hCAFE_F00D);
        add("pc4_wrap",  2, 3'b000, 1, 3,  32'h0000_0055, 32'hFFFF_FFFC, 32'h0,         1, 3,  32'h0000_0000);
        add("zero_sel",  3, 3'b000, 1, 4,  32'h0000_DEAD, 32'h0,         32'h1,         1, 4,  32'h0000_0000);
        add("rd0_no_we", 0, 3'b000, 1, 0,  32'h0000_DEAD, 32'h0,         32'h0,         0, 0,  32'h0000_DEAD);
        add("we0",       0, 3'b000, 0, 9,  32'h0000_0055, 32'h0,         32'h0,         0, 9,  32'h0000_0055);

        // Reset state
        #12;
        chk("rst_we",   {31'd0, write_enable}, 32'd0);
        chk("rst_addr", {27'd0, addr_rd}, 32'd0);
        chk("rst_data", data_rd, 32'd0);
        @(negedge clk); rst = 1'b0;
        tick();
        chk("post_rst_we", {31'd0, write_enable}, 32'd0);

        // Table-driven single-cycle vectors
        foreach (vecs[i]) begin
            drive(vecs[i].wb_sel, vecs[i].f3, vecs[i].we, vecs[i].rd,
                  vecs[i].alu, vecs[i].pc, vecs[i].mem);
            tick();
            chk({vecs[i].name, "_we"},   {31'd0, write_enable}, {31'd0, vecs[i].exp_we});
            chk({vecs[i].name, "_addr"}, {27'd0, addr_rd}, {27'd0, vecs[i].exp_rd});
            chk({vecs[i].name, "_data"}, data_rd, vecs[i].exp_data);
        end

        // x0 is never bypassed
        drive(0, 3'b000, 1, 0, 32'h0000_DEAD, 32'h0, 32'h0);
        tick();
        id_rs1 = 5'd0; id_rf_rs1 = 32'h0BAD_0001; #1;
        chk("x0_no_bypass", id_rs1_data, 32'h0BAD_0001);

        // WB->ID bypass on rs2, pass-through on rs1
        drive(0, 3'b000, 1, 7, 32'h1234_5678, 32'h0, 32'h0);
        tick();
        id_rs2 = 5'd7; id_rf_rs2 = 32'h0; id_rs1 = 5'd8; id_rf_rs1 = 32'hA5A5_5A5A; #1;
        chk("byp_rs2", id_rs2_data, 32'h1234_5678);
        chk("byp_rs1_pass", id_rs1_data, 32'hA5A5_5A5A);

        // JAL then 3 stall cycles: exactly one write
`ifdef WB_RETIRE_COUNTER_EN
        rc_before = retire_count;
`endif
        drive(2, 3'b000, 1, 1, 32'h0, 32'h0100_0010, 32'h0);
        tick();
        wcnt = int'(write_enable);
        chk("jal_data", data_rd, 32'h0100_0014);
        chk("jal_addr", {27'd0, addr_rd}, 32'd1);
        stall = 1'b1; in_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            wcnt += int'(write_enable);
            // rs1 bypass must also stop once the write has landed
            id_rs1 = 5'd1; id_rf_rs1 = 32'h0000_0777; #1;
            chk("jal_stall_no_byp", id_rs1_data, 32'h0000_0777);
        end
        chk("jal_single_write", wcnt, 1);
`ifdef WB_RETIRE_COUNTER_EN
        chk("jal_retire_once", retire_count[31:0] - rc_before[31:0], 32'd1);
`endif
        stall = 1'b0;

        // flush + stall on a valid ALU op: squashed, no write
        drive(0, 3'b000, 1, 6, 32'h0000_0077, 32'h0, 32'h0);
        flush = 1'b1; stall = 1'b1;
        tick();
        chk("flush_stall_we", {31'd0, write_enable}, 32'd0);
        flush = 1'b0;
        tick();
        chk("flush_then_stall_we", {31'd0, write_enable}, 32'd0);
        stall = 1'b0;

        // reset pulsed mid-stall
        drive(0, 3'b000, 1, 10, 32'h0000_0099, 32'h0, 32'h0);
        tick();
        chk("pre_rst_we", {31'd0, write_enable}, 32'd1);
        stall = 1'b1;
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_we",   {31'd0, write_enable}, 32'd0);
        chk("mid_rst_addr", {27'd0, addr_rd}, 32'd0);
        chk("mid_rst_data", data_rd, 32'd0);
        @(negedge clk); rst = 1'b0;
        tick();
        chk("after_rst_we", {31'd0, write_enable}, 32'd0);
        stall = 1'b0;
        tick();
        chk("after_rst_capture_we", {31'd0, write_enable}, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
